// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] PC_INC               = 32'd4;
    localparam logic [PC_W-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [PC_W-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } pc_state_e;

    // Instruction fetches are word aligned; any set low bit is a fault.
    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return |lsb;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Priority select of the next fetch address plus redirect-alignment check.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter logic [PC_W-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic            run,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] epc,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            trap,
    input  logic            mret,
    input  logic            fetch_ready,
    output logic [PC_W-1:0] next_pc,
    output logic            flush_req,
    output logic            trap_req,
    output logic            misaligned_req
);

    logic            redirect;
    logic [PC_W-1:0] redirect_target;

    always_comb begin
        // NOTE: every output gets a default first so no latch can be inferred.
        redirect        = 1'b0;
        redirect_target = jump_target;
        if (jump) begin
            redirect        = 1'b1;
            redirect_target = jump_target;
        end else if (branch_taken) begin
            redirect        = 1'b1;
            redirect_target = branch_target;
        end
    end

    always_comb begin
        next_pc        = pc;
        flush_req      = 1'b0;
        trap_req       = 1'b0;
        misaligned_req = 1'b0;
        if (run) begin
            if (trap) begin
                trap_req = 1'b1;
            end else if (mret) begin
                next_pc   = epc;
                flush_req = 1'b1;
            end else if (redirect) begin
                if (addr_misaligned(redirect_target[1:0])) begin
                    trap_req       = 1'b1;
                    misaligned_req = 1'b1;
                end else begin
                    next_pc   = redirect_target;
                    flush_req = 1'b1;
                end
            end else if (!stall && fetch_ready) begin
                next_pc = pc + PC_INC;  // wraps modulo 2^32
            end
        end
        if (trap_req) begin
            next_pc   = TRAP_VECTOR;
            flush_req = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: boot delay, sequential fetch, redirects, trap entry/return.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [PC_W-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
    parameter int              BOOT_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            trap,
    input  logic            mret,
    input  logic            fetch_ready,
    output logic [PC_W-1:0] pc_out,
    output logic            fetch_valid,
    output logic            flush,
    output logic [PC_W-1:0] epc_out,
    output logic            misaligned
);

    localparam logic [1:0] ST_BOOT   = BOOT;
    localparam logic [1:0] ST_RUN    = RUN;
    localparam logic [1:0] ST_BUBBLE = BUBBLE;
    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    logic [1:0]      state;
    logic [3:0]      boot_cnt;
    logic [PC_W-1:0] next_pc;
    logic            flush_req;
    logic            trap_req;
    logic            misaligned_req;

    assign fetch_valid = (state == ST_RUN);

    pc_next_sel #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next_sel (
        .run            (fetch_valid),
        .pc             (pc_out),
        .epc            (epc_out),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .trap           (trap),
        .mret           (mret),
        .fetch_ready    (fetch_ready),
        .next_pc        (next_pc),
        .flush_req      (flush_req),
        .trap_req       (trap_req),
        .misaligned_req (misaligned_req)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_BOOT;
            boot_cnt   <= 4'd0;
            pc_out     <= RESET_VECTOR;
            epc_out    <= '0;
            flush      <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            pc_out     <= next_pc;
            flush      <= flush_req;
            misaligned <= misaligned_req;
            if (trap_req) begin
                epc_out <= pc_out;
            end
            case (state)
                ST_BOOT: begin
                    if (boot_cnt == BOOT_LAST) begin
                        state <= ST_RUN;
                    end else begin
                        boot_cnt <= boot_cnt + 4'd1;
                    end
                end
                ST_RUN: begin
                    if (trap_req) begin
                        state <= ST_BUBBLE;
                    end
                end
                ST_BUBBLE: state <= ST_RUN;
                default:   state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        trap;
    logic        mret;
    logic        fetch_ready;
    logic [31:0] pc_out;
    logic        fetch_valid;
    logic        flush;
    logic [31:0] epc_out;
    logic        misaligned;

    int check_cnt = 0;
    int pass_cnt  = 0;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .mret          (mret),
        .fetch_ready   (fetch_ready),
        .pc_out        (pc_out),
        .fetch_valid   (fetch_valid),
        .flush         (flush),
        .epc_out       (epc_out),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Advance one rising edge and settle; inputs are then driven for the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        stall        = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        trap         = 1'b0;
        mret         = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        branch_target = 32'h0;
        jump_target   = 32'h0;
        fetch_ready   = 1'b1;
        clear_events();
        step();
        step();
        check("rst_pc",    pc_out, 32'h0);
        check("rst_fv",    32'(fetch_valid), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_epc",   epc_out, 32'h0);
        check("rst_mis",   32'(misaligned), 32'h0);

        // Boot: two idle edges, then 0, 4, 8
        reset = 1'b0;
        step();
        check("boot1_fv", 32'(fetch_valid), 32'h0);
        step();
        check("boot2_fv", 32'(fetch_valid), 32'h1);
        check("seq_pc0",  pc_out, 32'h0);
        step();
        check("seq_pc4",  pc_out, 32'h4);
        step();
        check("seq_pc8",  pc_out, 32'h8);

        // Memory not ready: hold
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_pc", pc_out, 32'h8);
            check("hold_fv", 32'(fetch_valid), 32'h1);
        end
        fetch_ready = 1'b1;
        step();
        check("ready_pc", pc_out, 32'hC);
        step();
        check("pc10", pc_out, 32'h10);

        // jump beats branch
        jump = 1'b1; jump_target = 32'h40;
        branch_taken = 1'b1; branch_target = 32'h80;
        step();
        clear_events();
        check("jmp_pc",    pc_out, 32'h40);
        check("jmp_flush", 32'(flush), 32'h1);
        step();
        check("jmp_pc_next", pc_out, 32'h44);
        check("jmp_flush_end", 32'(flush), 32'h0);

        // Trap with stall at 0x20, then mret
        jump = 1'b1; jump_target = 32'h20;
        step();
        clear_events();
        check("pc20", pc_out, 32'h20);
        trap = 1'b1; stall = 1'b1;
        step();
        clear_events();
        check("trap_epc",   epc_out, 32'h20);
        check("trap_pc",    pc_out, 32'h100);
        check("trap_fv",    32'(fetch_valid), 32'h0);
        check("trap_flush", 32'(flush), 32'h1);
        step();
        check("bubble_end_fv", 32'(fetch_valid), 32'h1);
        check("bubble_end_pc", pc_out, 32'h100);
        check("bubble_end_flush", 32'(flush), 32'h0);
        step();
        check("handler_pc", pc_out, 32'h104);
        mret = 1'b1;
        step();
        clear_events();
        check("mret_pc",    pc_out, 32'h20);
        check("mret_flush", 32'(flush), 32'h1);
        check("mret_epc",   epc_out, 32'h20);

        // Misaligned branch at 0x30
        jump = 1'b1; jump_target = 32'h30;
        step();
        clear_events();
        check("pc30", pc_out, 32'h30);
        branch_taken = 1'b1; branch_target = 32'h42;
        step();
        clear_events();
        check("mis_flag",  32'(misaligned), 32'h1);
        check("mis_flush", 32'(flush), 32'h1);
        check("mis_epc",   epc_out, 32'h30);
        check("mis_pc",    pc_out, 32'h100);
        check("mis_fv",    32'(fetch_valid), 32'h0);
        step();
        check("mis_flag_end", 32'(misaligned), 32'h0);
        check("mis_fv_end",   32'(fetch_valid), 32'h1);

        // Stall holds; redirect overrides stall; wrap at 2^32
        stall = 1'b1;
        step();
        check("stall_pc", pc_out, 32'h100);
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step();
        clear_events();
        check("stall_jmp_pc", pc_out, 32'hFFFF_FFFC);
        step();
        check("wrap_pc", pc_out, 32'h0);

        // Trap into BUBBLE, then asynchronous reset mid-cycle
        trap = 1'b1;
        step();
        clear_events();
        check("pre_rst_fv",    32'(fetch_valid), 32'h0);
        check("pre_rst_flush", 32'(flush), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("arst_pc",    pc_out, 32'h0);
        check("arst_flush", 32'(flush), 32'h0);
        check("arst_epc",   epc_out, 32'h0);
        check("arst_fv",    32'(fetch_valid), 32'h0);

        // Events during BOOT are ignored
        step();
        reset = 1'b0;
        jump = 1'b1; jump_target = 32'h80;
        step();
        check("boot_ev_fv", 32'(fetch_valid), 32'h0);
        check("boot_ev_pc", pc_out, 32'h0);
        clear_events();
        step();
        check("reboot_fv", 32'(fetch_valid), 32'h1);
        check("reboot_pc", pc_out, 32'h0);
        check("reboot_flush", 32'(flush), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
